mmac_seq_engine: RTL and testbench
==================================

# mmac_seq_engine

Parametrised sequential matrix multiply-accumulate engine: computes C = A×B or C = C + A×B for signed N×N matrices with one MAC per cycle and saturating accumulation. Operands stream in one row per beat over a valid/ready handshake, and results stream out the same way. The C array persists between jobs, so successive jobs chain into one accumulated result. It is the successor to the fixed 4×4 combinational matrix MAC and sits between the operand buffers and the result writeback path.

## Interface
- `N`, 4: matrix dimension (N ≥ 2, power of two).
- `DW`, 8: element width, signed two's complement.
- `ACC_W`, 24: C element width, signed; must satisfy ACC_W ≥ 2·DW + log2(N).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clear` in 1: zero the C array (see Operation).
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: engine accepts operand beat.
- `in_accum` in 1: accumulate mode; sampled on beat 0 only.
- `in_a` in N·DW: row r of A; element j at bits [j·DW +: DW].
- `in_b` in N·DW: row r of B, same packing.
- `out_valid` out 1: result row valid.
- `out_ready` in 1: downstream accepts row.
- `out_row` out N·ACC_W: row r of C; element j at [j·ACC_W +: ACC_W].
- `out_last` out 1: high with row N-1.
- `sat` out 1: at least one saturation occurred in the current job; valid while out_valid.
- `busy` out 1: high unless in LOAD with zero beats taken.

## Operation
- FSM states: LOAD → COMPUTE → DRAIN → LOAD.
- LOAD:
  - in_ready = 1.
  - Each accepted beat (in_valid & in_ready) writes A row r and B row r, where r is the row counter 0..N-1.
  - After beat N-1 the FSM goes to COMPUTE.
- COMPUTE:
  - Runs for exactly N³ cycles, with loop indices i, j, k and k innermost.
  - On k = 0, the partial sum is seeded with C[i][j] if the job's accum flag is 1, else with 0.
  - Each cycle adds A[i][k]·B[k][j].
  - On k = N-1, the saturated sum is written to C[i][j].
  - The `sat` flag clears on entry to COMPUTE.
- DRAIN:
  - out_valid = 1 and out_row = C row r.
  - r advances on out_valid & out_ready.
  - After the row N-1 handshake the FSM returns to LOAD with r = 0.
  - The C array is retained after DRAIN.
- Arithmetic:
  - The product is a full 2·DW-bit signed value, sign-extended to ACC_W+1 bits.
  - The sum is computed at ACC_W+1 bits and clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any clamp sets `sat`.
- clear:
  - Honoured only in LOAD with r = 0; ignored in every other state.
  - The C array reads zero from the next cycle.
  - If clear coincides with beat 0, the beat is still accepted. The accum flag is captured as given but has no effect, because C is zero.
- Mid-job reset: aborts immediately. The FSM goes to LOAD, counters, C, A and B are zeroed, and no partial output is emitted.

## Timing
- Values while reset is low: in_ready = 0. out_valid, out_last, sat, busy and out_row are all 0. C = 0.
- First cycle after reset deassertion: in_ready = 1, FSM in LOAD.
- Latency: last load beat accepted at edge t → first COMPUTE cycle at t+1 → out_valid rises at t+1+N³ (65 cycles for N = 4).
- Drain takes N cycles with no backpressure.
- Job period with no stalls: N + N³ + N cycles (72 for N = 4).
- out_row, out_last and sat hold stable while out_valid & !out_ready.
- in_valid may drop between load beats; r holds its value.
- in_ready is 0 in COMPUTE and DRAIN. There is no overlap of load with drain.

## Structure
- `mmac_pkg` holds:
  - the FSM state enum `mmac_state_e`;
  - default constants MMAC_N, MMAC_DW, MMAC_ACC_W;
  - a `sat_add` function (ACC_W+1-bit add with clamp).
- One sub-module, `mmac_sat_mac`: the registered partial-sum datapath with seed select, multiply, add and clamp. It outputs the sum and a saturation flag.
- A, B and C are register arrays in the top level. Index counters and the FSM live in the top level.

## Test plan
1. A = identity, B[i][j] = 4i+j+1, accum = 0 → rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}; out_last on the 4th row; sat = 0.
2. Same job repeated with accum = 1 → every element doubles ({2,4,6,8} …).
3. DW = 8, ACC_W = 16, A = B = all −128, accum = 1, run 3 jobs:
   - job 1 elements = 65536 → clamp to 32767, sat = 1;
   - jobs 2 and 3 stay at 32767, sat = 1.
4. Hold out_ready low for 5 cycles during row 1 → row 1 data stable, no row skipped or duplicated, out_valid rises exactly 65 cycles after the last load beat.
5. After a job leaving C ≠ 0: clear with beat 0 and accum = 1, A = identity, B = ones → all outputs are 1. clear asserted in DRAIN → no effect.
6. Assert reset 20 cycles into COMPUTE → outputs zero immediately; after release in_ready = 1; the next accum = 1 job behaves as from C = 0.

Source files
------------

// File: rtl/mmac_pkg.sv
// Shared types and helpers for the sequential matrix MAC engine: FSM states,
// default geometry and the clamping adder used by the MAC datapath.
package mmac_pkg;

  localparam int MMAC_N     = 4;
  localparam int MMAC_DW    = 8;
  localparam int MMAC_ACC_W = 24;
  localparam int MMAC_MAXW  = 64;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } mmac_state_e;

  typedef struct packed {
    logic                        sat;
    logic signed [MMAC_MAXW-1:0] sum;
  } sat_res_t;

  // Operands already fit in acc_w+1 bits; the add is done wide and clamped to acc_w.
  function automatic sat_res_t sat_add(input logic signed [MMAC_MAXW-1:0] x,
                                       input logic signed [MMAC_MAXW-1:0] y,
                                       input int unsigned                 acc_w);
    logic signed [MMAC_MAXW-1:0] s;
    logic signed [MMAC_MAXW-1:0] hi;
    logic signed [MMAC_MAXW-1:0] lo;
    sat_res_t                    res;
    s  = x + y;
    hi = (64'sd1 <<< (acc_w - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      res.sum = hi;
      res.sat = 1'b1;
    end else if (s < lo) begin
      res.sum = lo;
      res.sat = 1'b1;
    end else begin
      res.sum = s;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mmac_seq_engine_if.sv
// Operand/result streaming bundle of the matrix MAC engine; the engine is the
// slave, the operand source / result sink is the master.
interface mmac_seq_engine_if import mmac_pkg::*; #(
  parameter int N     = MMAC_N,
  parameter int DW    = MMAC_DW,
  parameter int ACC_W = MMAC_ACC_W
) ();

  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic              in_accum;
  logic [N*DW-1:0]   in_a;
  logic [N*DW-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [N*ACC_W-1:0] out_row;
  logic              out_last;
  logic              sat;
  logic              busy;

  modport master (
    output clear, in_valid, in_accum, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_row, out_last, sat, busy
  );

  modport slave (
    input  clear, in_valid, in_accum, in_a, in_b, out_ready,
    output in_ready, out_valid, out_row, out_last, sat, busy
  );

endinterface

// File: rtl/mmac_sat_mac.sv
// Registered partial-sum datapath: seeds on the first k step, adds one signed
// product per cycle and clamps every step so the running sum stays in range.
module mmac_sat_mac import mmac_pkg::*; #(
  parameter int DW    = MMAC_DW,
  parameter int ACC_W = MMAC_ACC_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    first,
  input  logic signed [ACC_W-1:0] seed,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sat
);

  logic signed [ACC_W-1:0]     psum_q;
  logic signed [ACC_W-1:0]     psum_d;
  logic signed [2*DW-1:0]      prod_s;
  logic signed [MMAC_MAXW-1:0] base_s;
  sat_res_t                    res_s;

  // Seed select, multiply and saturating add for the current k step
  always_comb begin
    prod_s = a * b;
    if (first) begin
      base_s = MMAC_MAXW'(seed);
    end else begin
      base_s = MMAC_MAXW'(psum_q);
    end
    res_s = sat_add(base_s, MMAC_MAXW'(prod_s), ACC_W);
    sum   = res_s.sum[ACC_W-1:0];
    sat   = res_s.sat;
    if (en) begin
      psum_d = sum;
    end else begin
      psum_d = psum_q;
    end
  end

  // Partial-sum register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      psum_q <= {ACC_W{1'b0}};
    end else begin
      psum_q <= psum_d;
    end
  end

endmodule

// File: rtl/mmac_seq_engine.sv
// Sequential N x N matrix multiply-accumulate: loads A/B one row per beat,
// runs N^3 MAC cycles into the persistent C array, then streams C out by row.
module mmac_seq_engine import mmac_pkg::*; #(
  parameter int N     = MMAC_N,
  parameter int DW    = MMAC_DW,
  parameter int ACC_W = MMAC_ACC_W
) (
  input logic              clock,
  input logic              reset,
  mmac_seq_engine_if.slave bus
);

  localparam int            LW       = $clog2(N);
  localparam logic [LW-1:0] IDX_LAST = LW'(N - 1);
  localparam logic [LW-1:0] IDX_ZERO = {LW{1'b0}};

  mmac_state_e             state_q, state_d;
  logic [LW-1:0]           r_q, r_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic                    accum_q, accum_d, sat_q, sat_d;
  logic signed [DW-1:0]    a_q [N][N];
  logic signed [DW-1:0]    a_d [N][N];
  logic signed [DW-1:0]    b_q [N][N];
  logic signed [DW-1:0]    b_d [N][N];
  logic signed [ACC_W-1:0] c_q [N][N];
  logic signed [ACC_W-1:0] c_d [N][N];
  logic                    mac_en_s, mac_first_s, mac_sat_s;
  logic signed [ACC_W-1:0] mac_seed_s, mac_sum_s;

  assign mac_first_s = (k_q == IDX_ZERO);
  assign mac_seed_s  = accum_q ? c_q[i_q][j_q] : {ACC_W{1'b0}};

  mmac_sat_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clock (clock),
    .reset (reset),
    .en    (mac_en_s),
    .first (mac_first_s),
    .seed  (mac_seed_s),
    .a     (a_q[i_q][k_q]),
    .b     (b_q[k_q][j_q]),
    .sum   (mac_sum_s),
    .sat   (mac_sat_s)
  );

  // Next-state, counters and array updates
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    accum_d  = accum_q;
    sat_d    = sat_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    mac_en_s = 1'b0;
    case (state_q)
      ST_LOAD: begin
        // clear is only meaningful before any beat of the job has landed
        if (bus.clear && (r_q == IDX_ZERO)) begin
          for (int ii = 0; ii < N; ii++) begin
            for (int jj = 0; jj < N; jj++) begin
              c_d[ii][jj] = {ACC_W{1'b0}};
            end
          end
        end else begin
          c_d = c_q;
        end
        if (bus.in_valid) begin
          for (int jj = 0; jj < N; jj++) begin
            a_d[r_q][jj] = bus.in_a[jj*DW +: DW];
            b_d[r_q][jj] = bus.in_b[jj*DW +: DW];
          end
          if (r_q == IDX_ZERO) begin
            accum_d = bus.in_accum;
          end else begin
            accum_d = accum_q;
          end
          if (r_q == IDX_LAST) begin
            state_d = ST_COMPUTE;
            sat_d   = 1'b0;
            r_d     = IDX_ZERO;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          r_d = r_q;
        end
      end
      ST_COMPUTE: begin
        mac_en_s = 1'b1;
        sat_d    = sat_q | mac_sat_s;
        k_d      = k_q + 1'b1;
        if (k_q == IDX_LAST) begin
          c_d[i_q][j_q] = mac_sum_s;
          j_d           = j_q + 1'b1;
          if (j_q == IDX_LAST) begin
            i_d = i_q + 1'b1;
            if (i_q == IDX_LAST) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_COMPUTE;
            end
          end else begin
            i_d = i_q;
          end
        end else begin
          j_d = j_q;
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          r_d = r_q + 1'b1;
          if (r_q == IDX_LAST) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          r_d = r_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
        r_d     = IDX_ZERO;
      end
    endcase
  end

  // State, counters and operand/result arrays
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      r_q     <= IDX_ZERO;
      i_q     <= IDX_ZERO;
      j_q     <= IDX_ZERO;
      k_q     <= IDX_ZERO;
      accum_q <= 1'b0;
      sat_q   <= 1'b0;
      for (int ii = 0; ii < N; ii++) begin
        for (int jj = 0; jj < N; jj++) begin
          a_q[ii][jj] <= {DW{1'b0}};
          b_q[ii][jj] <= {DW{1'b0}};
          c_q[ii][jj] <= {ACC_W{1'b0}};
        end
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      accum_q <= accum_d;
      sat_q   <= sat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  // Status and result outputs, all decoded from registered state
  always_comb begin
    bus.in_ready  = reset && (state_q == ST_LOAD);
    bus.out_valid = (state_q == ST_DRAIN);
    bus.out_last  = (state_q == ST_DRAIN) && (r_q == IDX_LAST);
    bus.sat       = sat_q;
    bus.busy      = !((state_q == ST_LOAD) && (r_q == IDX_ZERO));
    bus.out_row   = {(N*ACC_W){1'b0}};
    for (int jj = 0; jj < N; jj++) begin
      if (state_q == ST_DRAIN) begin
        bus.out_row[jj*ACC_W +: ACC_W] = c_q[r_q][jj];
      end else begin
        bus.out_row[jj*ACC_W +: ACC_W] = {ACC_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_mmac_seq_engine.sv
// Directed bench for mmac_seq_engine: a matrix-level model predicts every drained row.
module tb_mmac_seq_engine;

  typedef struct packed {
    logic [95:0] row;
    logic        last;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        drv_valid = 1'b0;
  logic        drv_accum = 1'b0;
  logic        drv_clear = 1'b0;
  logic        drv_ready = 1'b1;
  logic [31:0] drv_a = 32'd0;
  logic [31:0] drv_b = 32'd0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          beat_cyc [2];
  bit          ov_prev [2];
  longint      mA [4][4];
  longint      mB [4][4];
  longint      mC [2][4][4];
  exp_t        exp0 [$];
  exp_t        exp1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmac_seq_engine_if #(.N(4), .DW(8), .ACC_W(24)) if0 ();
  mmac_seq_engine_if #(.N(4), .DW(8), .ACC_W(16)) if1 ();

  assign if0.clear     = drv_clear & ~sel;
  assign if0.in_valid  = drv_valid & ~sel;
  assign if0.in_accum  = drv_accum;
  assign if0.in_a      = drv_a;
  assign if0.in_b      = drv_b;
  assign if0.out_ready = drv_ready;
  assign if1.clear     = drv_clear & sel;
  assign if1.in_valid  = drv_valid & sel;
  assign if1.in_accum  = drv_accum;
  assign if1.in_a      = drv_a;
  assign if1.in_b      = drv_b;
  assign if1.out_ready = drv_ready;

  mmac_seq_engine #(.N(4), .DW(8), .ACC_W(24)) dut0 (.clock(clk), .reset(rst_n), .bus(if0.slave));
  mmac_seq_engine #(.N(4), .DW(8), .ACC_W(16)) dut1 (.clock(clk), .reset(rst_n), .bus(if1.slave));

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  // kind 0: A = I, B = 4i+j+1; kind 1: A = I, B = ones; kind 2: A = B = -128
  task automatic set_ops(input int kind);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (kind == 2) begin
          mA[i][j] = -128;
          mB[i][j] = -128;
        end else begin
          mA[i][j] = (i == j) ? 1 : 0;
          mB[i][j] = (kind == 0) ? (4 * i + j + 1) : 1;
        end
      end
    end
  endtask

  // Matrix-level reference: per-step saturating dot products, whole-job sat flag
  task automatic model_job(input int d, input bit accum);
    longint hi, lo, s;
    bit     sat;
    exp_t   e;
    hi  = (d == 0) ? 64'sd8388607 : 64'sd32767;
    lo  = -hi - 1;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = accum ? mC[d][i][j] : 0;
        for (int k = 0; k < 4; k++) begin
          s = s + mA[i][k] * mB[k][j];
          if (s > hi) begin s = hi; sat = 1'b1; end
          else if (s < lo) begin s = lo; sat = 1'b1; end
        end
        mC[d][i][j] = s;
      end
    end
    for (int i = 0; i < 4; i++) begin
      e.row = 96'd0;
      for (int j = 0; j < 4; j++) begin
        if (d == 0) e.row[j*24 +: 24] = mC[d][i][j][23:0];
        else        e.row[j*16 +: 16] = mC[d][i][j][15:0];
      end
      e.last = (i == 3);
      e.sat  = sat;
      if (d == 0) exp0.push_back(e);
      else        exp1.push_back(e);
    end
  endtask

  task automatic load_job(input int d, input bit accum, input bit clr, input bit gap);
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      if (gap && r == 2) begin
        drv_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
      sel       = d[0];
      drv_valid = 1'b1;
      drv_accum = accum;
      drv_clear = clr && (r == 0);
      for (int j = 0; j < 4; j++) begin
        drv_a[j*8 +: 8] = mA[r][j][7:0];
        drv_b[j*8 +: 8] = mB[r][j][7:0];
      end
      beat_cyc[d] = cyc;
      @(negedge clk);
      chk("in_ready_load", (d == 0) ? if0.in_ready : if1.in_ready, 96'd1);
    end
    @(posedge clk); #1;
    drv_valid = 1'b0;
    drv_clear = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (qsize(d) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done_rows_left", qsize(d), 96'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid0();
    int n = 0;
    while (!if0.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", if0.out_valid, 96'd1);
  endtask

  task automatic check_port(input int d, input logic ov, input logic rdy, input logic [95:0] row,
                            input logic last, input logic sat, input logic inr);
    exp_t e;
    if (ov) begin
      if (!ov_prev[d]) chk("latency_last_beat_to_out_valid", cyc - beat_cyc[d], 96'd65);
      chk("in_ready_during_drain", inr, 96'd0);
      if (qsize(d) == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_row dut%0d: got row %0h, expected no row", d, row);
      end else begin
        e = (d == 0) ? exp0[0] : exp1[0];
        chk("out_row", row, e.row);
        chk("out_last", last, e.last);
        chk("sat", sat, e.sat);
        if (rdy) begin
          if (d == 0) void'(exp0.pop_front());
          else        void'(exp1.pop_front());
        end
      end
    end
    ov_prev[d] = ov;
  endtask

  // Compare process: every drained or stalled row against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev[0] = 1'b0;
      ov_prev[1] = 1'b0;
    end else begin
      check_port(0, if0.out_valid, if0.out_ready, if0.out_row, if0.out_last, if0.sat, if0.in_ready);
      check_port(1, if1.out_valid, if1.out_ready, {32'd0, if1.out_row}, if1.out_last, if1.sat,
                 if1.in_ready);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mC[d][i][j] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", if0.in_ready, 96'd0);
    chk("rst_in_ready_dut1", if1.in_ready, 96'd0);
    chk("rst_out_valid", if0.out_valid, 96'd0);
    chk("rst_busy", if0.busy, 96'd0);
    chk("rst_out_row", if0.out_row, 96'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", if0.in_ready, 96'd1);
    chk("post_rst_busy", if0.busy, 96'd0);

    // Test 1: identity times pattern, with a gap between load beats
    set_ops(0);
    model_job(0, 1'b0);
    chk("pin_t1_c00", mC[0][0][0], 96'd1);
    chk("pin_t1_c12", mC[0][1][2], 96'd7);
    chk("pin_t1_c33", mC[0][3][3], 96'd16);
    load_job(0, 1'b0, 1'b0, 1'b1);
    chk("busy_compute", if0.busy, 96'd1);
    wait_drain(0);

    // Test 2: same job accumulated, every element doubles
    model_job(0, 1'b1);
    chk("pin_t2_c01", mC[0][0][1], 96'd4);
    chk("pin_t2_c33", mC[0][3][3], 96'd32);
    load_job(0, 1'b1, 1'b0, 1'b0);
    wait_drain(0);

    // Test 4: stall row 1 for five cycles
    model_job(0, 1'b1);
    load_job(0, 1'b1, 1'b0, 1'b0);
    begin
      int n = 0;
      while (exp0.size() != 3 && n < 200) begin @(negedge clk); n++; end
    end
    @(posedge clk); #1;
    drv_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    drv_ready = 1'b1;
    wait_drain(0);

    // Test 5: clear with beat 0 (accum given but C is zero), then clear in DRAIN is ignored
    set_ops(1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) mC[0][i][j] = 0;
    model_job(0, 1'b1);
    chk("pin_t5_c22", mC[0][2][2], 96'd1);
    load_job(0, 1'b1, 1'b1, 1'b0);
    wait_drain(0);
    model_job(0, 1'b1);
    chk("pin_t5b_c00", mC[0][0][0], 96'd2);
    load_job(0, 1'b1, 1'b0, 1'b0);
    wait_out_valid0();
    @(posedge clk); #1;
    sel = 1'b0;
    drv_clear = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    drv_clear = 1'b0;
    wait_drain(0);
    model_job(0, 1'b1);
    load_job(0, 1'b1, 1'b0, 1'b0);
    wait_drain(0);

    // Test 3: ACC_W = 16 saturation across three chained jobs
    set_ops(2);
    for (int jb = 0; jb < 3; jb++) begin
      model_job(1, 1'b1);
      if (jb == 0) chk("pin_t3_clamp", mC[1][2][1], 96'd32767);
      load_job(1, 1'b1, 1'b0, 1'b0);
      wait_drain(1);
    end

    // Test 6: reset 20 cycles into COMPUTE aborts the job and zeroes C
    set_ops(0);
    load_job(0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_before_abort", if0.busy, 96'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", if0.in_ready, 96'd0);
    chk("abort_out_valid", if0.out_valid, 96'd0);
    chk("abort_busy", if0.busy, 96'd0);
    chk("abort_sat", if0.sat, 96'd0);
    chk("abort_out_last", if0.out_last, 96'd0);
    chk("abort_out_row", if0.out_row, 96'd0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mC[d][i][j] = 0;
    exp0.delete();
    exp1.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_in_ready", if0.in_ready, 96'd1);
    chk("abort_release_busy", if0.busy, 96'd0);
    model_job(0, 1'b1);
    chk("pin_t6_c30", mC[0][3][0], 96'd13);
    load_job(0, 1'b1, 1'b0, 1'b0);
    wait_drain(0);

    repeat (5) @(posedge clk);
    chk("rows_outstanding_at_end", qsize(0) + qsize(1), 96'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
